seg_disp_rx: RTL and testbench

//  Receiver for the multiplexed 6-digit 7-segment display bus (seg/dp/enb) driven by the clock top.

---
 rtl/seg_disp_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_seg_disp_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_rx.sv
// Receiver for the multiplexed 6-digit 7-segment display bus. It synchronizes the bus,
// waits for each digit slot to settle, decodes the segments and reassembles 6-digit frames.
module seg_disp_rx #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    input  logic        i_err_clr,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_valid,
    output logic        o_link_ok,
    output logic        o_err
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_CYC);

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'h7E:   code = 4'h0;
            7'h30:   code = 4'h1;
            7'h6D:   code = 4'h2;
            7'h79:   code = 4'h3;
            7'h33:   code = 4'h4;
            7'h5B:   code = 4'h5;
            7'h5F:   code = 4'h6;
            7'h70:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h73:   code = 4'h9;
            7'h77:   code = 4'hA;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    logic [6:0]    seg_m_r, seg_s_r, seg_p_r;
    logic          dp_m_r, dp_s_r;
    logic [5:0]    enb_m_r, enb_s_r, enb_p_r;
    logic [SW-1:0] settle_cnt_r;
    logic          armed_r;
    logic [TW-1:0] tmo_cnt_r;
    state_t        state_r, state_next_s;
    logic [2:0]    exp_r, exp_next_s;
    logic [23:0]   buf_digits_r;
    logic [5:0]    buf_dp_r;
    logic          commit_r;

    logic          enb_chg_s, bus_chg_s;
    logic          slot_ok_s, blank_s, illegal_s;
    logic [2:0]    slot_s;
    logic          capture_s, timeout_s, store_s, commit_s;

    // Two-flop synchronizer plus previous-value copy; enables idle high (blank) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m_r <= 7'h00;
            seg_s_r <= 7'h00;
            seg_p_r <= 7'h00;
            dp_m_r  <= 1'b0;
            dp_s_r  <= 1'b0;
            enb_m_r <= 6'h3F;
            enb_s_r <= 6'h3F;
            enb_p_r <= 6'h3F;
        end else begin
            seg_m_r <= i_seg;
            seg_s_r <= seg_m_r;
            seg_p_r <= seg_s_r;
            dp_m_r  <= i_seg_dp;
            dp_s_r  <= dp_m_r;
            enb_m_r <= i_seg_enb;
            enb_s_r <= enb_m_r;
            enb_p_r <= enb_s_r;
        end
    end

    // Classify the synchronized enable pattern and derive capture/timeout strobes.
    always_comb begin
        enb_chg_s = (enb_s_r != enb_p_r);
        bus_chg_s = enb_chg_s || (seg_s_r != seg_p_r);
        slot_ok_s = 1'b1;
        slot_s    = 3'd0;
        case (enb_s_r)
            6'b111110: slot_s = 3'd0;
            6'b111101: slot_s = 3'd1;
            6'b111011: slot_s = 3'd2;
            6'b110111: slot_s = 3'd3;
            6'b101111: slot_s = 3'd4;
            6'b011111: slot_s = 3'd5;
            default:   slot_ok_s = 1'b0;
        endcase
        blank_s   = (enb_s_r == 6'h3F);
        illegal_s = !slot_ok_s && !blank_s;
        // The armed flag limits a dwell to one capture even if seg glitches after it.
        capture_s = armed_r && slot_ok_s && !bus_chg_s && (settle_cnt_r == SETTLE_LAST);
        timeout_s = !capture_s && (tmo_cnt_r == TMO_LAST);
    end

    // Settle counter, re-arm flag and capture-timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= '0;
            armed_r      <= 1'b1;
            tmo_cnt_r    <= '0;
        end else begin
            if (bus_chg_s) begin
                settle_cnt_r <= '0;
            end else if (settle_cnt_r != SETTLE_MAX) begin
                settle_cnt_r <= settle_cnt_r + 1'b1;
            end
            if (enb_chg_s) begin
                armed_r <= 1'b1;
            end else if (capture_s) begin
                armed_r <= 1'b0;
            end
            if (capture_s) begin
                tmo_cnt_r <= '0;
            end else if (tmo_cnt_r != TMO_MAX) begin
                tmo_cnt_r <= tmo_cnt_r + 1'b1;
            end
        end
    end

    // Frame assembly: next state, expected slot, store and commit decisions.
    always_comb begin
        state_next_s = state_r;
        exp_next_s   = exp_r;
        store_s      = 1'b0;
        commit_s     = 1'b0;
        if (illegal_s || timeout_s) begin
            state_next_s = ST_HUNT;
            exp_next_s   = 3'd0;
        end else if (capture_s) begin
            case (state_r)
                ST_HUNT: begin
                    if (slot_s == 3'd0) begin
                        store_s      = 1'b1;
                        exp_next_s   = 3'd1;
                        state_next_s = ST_COLLECT;
                    end else begin
                        state_next_s = ST_HUNT;
                    end
                end
                ST_COLLECT: begin
                    if (slot_s == exp_r) begin
                        store_s = 1'b1;
                        if (slot_s == 3'd5) begin
                            commit_s     = 1'b1;
                            exp_next_s   = 3'd0;
                            state_next_s = ST_HUNT;
                        end else begin
                            exp_next_s = exp_r + 3'd1;
                        end
                    end else if (slot_s == 3'd0) begin
                        store_s    = 1'b1;
                        exp_next_s = 3'd1;
                    end else begin
                        exp_next_s   = 3'd0;
                        state_next_s = ST_HUNT;
                    end
                end
                default: begin
                    exp_next_s   = 3'd0;
                    state_next_s = ST_HUNT;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state, slot buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_HUNT;
            exp_r         <= 3'd0;
            buf_digits_r  <= 24'h000000;
            buf_dp_r      <= 6'h00;
            commit_r      <= 1'b0;
            o_digits      <= 24'h000000;
            o_dp          <= 6'h00;
            o_frame_valid <= 1'b0;
            o_link_ok     <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            exp_r    <= exp_next_s;
            commit_r <= commit_s;
            if (store_s) begin
                buf_digits_r[{slot_s, 2'b00} +: 4] <= seg_decode(seg_s_r);
                buf_dp_r[slot_s]                   <= dp_s_r;
            end
            if (commit_r) begin
                o_digits      <= buf_digits_r;
                o_dp          <= buf_dp_r;
                o_frame_valid <= 1'b1;
                o_link_ok     <= 1'b1;
            end else begin
                o_frame_valid <= 1'b0;
                if (timeout_s) begin
                    o_link_ok <= 1'b0;
                end
            end
            if (illegal_s) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_rx.sv
// Self-checking bench for seg_disp_rx: directed scenarios plus randomized frames, checked
// against a slot-level reference model of frame reassembly.
module tb_seg_disp_rx;

    localparam int SETTLE = 16;
    localparam int TMO    = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic        i_err_clr;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_frame_valid;
    logic        o_link_ok;
    logic        o_err;

    seg_disp_rx #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_seg_dp(i_seg_dp),
        .i_seg_enb(i_seg_enb), .i_err_clr(i_err_clr), .o_digits(o_digits),
        .o_dp(o_dp), .o_frame_valid(o_frame_valid), .o_link_ok(o_link_ok), .o_err(o_err)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    always @(negedge clk) begin
        if (o_frame_valid === 1'b1) frames_seen++;
    end

    typedef struct {
        logic [3:0] code;
        logic       dp;
    } ent_t;

    logic [6:0]  seg_tab [11] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                  7'h5F, 7'h70, 7'h7F, 7'h73, 7'h77};
    ent_t        q[$];
    logic [23:0] m_digits;
    logic [5:0]  m_dp;
    logic        m_link;
    logic        m_err;
    int          m_frames;
    logic [5:0]  last_enb;
    int          idle;

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 11; i++) begin
            if (seg_tab[i] == s) return 4'(i);
        end
        return 4'hF;
    endfunction

    function automatic logic [5:0] slot_enb(input int k);
        logic [5:0] one;
        one = 6'b000001 << k;
        return ~one;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_digits"}, 32'(o_digits), 32'(m_digits));
        check({tag, "_dp"}, 32'(o_dp), 32'(m_dp));
        check({tag, "_link"}, 32'(o_link_ok), 32'(m_link));
        check({tag, "_err"}, 32'(o_err), 32'(m_err));
        check({tag, "_frames"}, 32'(frames_seen), 32'(m_frames));
    endtask

    // Partial frame is a queue; a slot is accepted only if it equals the queue length.
    task automatic model_capture(input int slot, input logic [6:0] seg, input logic dp);
        ent_t e;
        e.code = ref_decode(seg);
        e.dp   = dp;
        if (slot == q.size()) begin
            q.push_back(e);
        end else if (slot == 0) begin
            q.delete();
            q.push_back(e);
        end else begin
            q.delete();
        end
        if (q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                m_digits[4*k +: 4] = q[k].code;
                m_dp[k]            = q[k].dp;
            end
            m_frames++;
            m_link = 1'b1;
            q.delete();
        end
        idle = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_digits = 24'h0;
        m_dp     = 6'h0;
        m_link   = 1'b0;
        m_err    = 1'b0;
        last_enb = 6'h3F;
        idle     = 0;
    endtask

    task automatic dwell(input logic [5:0] enb, input logic [6:0] seg, input logic dp,
                         input int cyc, input string tag);
        int s;
        @(posedge clk); #1;
        i_seg_enb = enb;
        i_seg     = seg;
        i_seg_dp  = dp;
        repeat (cyc) @(posedge clk);
        #1;
        s = -1;
        for (int k = 0; k < 6; k++) begin
            if (enb == slot_enb(k)) s = k;
        end
        if (s >= 0 && enb != last_enb) begin
            model_capture(s, seg, dp);
        end else begin
            if (s < 0 && enb != 6'h3F) begin
                m_err = 1'b1;
                q.delete();
            end
            idle += cyc;
            if (idle > TMO + 5) begin
                m_link = 1'b0;
                q.delete();
            end
        end
        last_enb = enb;
        check_all(tag);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                         input logic [5:0] dps, input string tag);
        logic [6:0] segs [6];
        segs = '{s0, s1, s2, s3, s4, s5};
        for (int k = 0; k < 6; k++) dwell(slot_enb(k), segs[k], dps[k], 40, tag);
    endtask

    initial begin
        logic [6:0] rseg;
        int         rslot;
        rst_n     = 1'b0;
        i_seg     = 7'h00;
        i_seg_dp  = 1'b0;
        i_seg_enb = 6'h3F;
        i_err_clr = 1'b0;
        m_frames  = 0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // 1: reference frame
        frame(7'h7E, 7'h30, 7'h6D, 7'h79, 7'h77, 7'h77, 6'b000001, "t1");
        check("t1_const_digits", 32'(o_digits), 32'h00AA3210);
        check("t1_const_dp", 32'(o_dp), 32'h01);
        check("t1_const_link", 32'(o_link_ok), 32'h1);

        // 2: glitching segments in slot 2, then a stable 5B, then a late change (no recapture)
        dwell(slot_enb(0), 7'h33, 1'b0, 40, "t2");
        dwell(slot_enb(1), 7'h7F, 1'b1, 40, "t2");
        @(posedge clk); #1;
        i_seg_enb = slot_enb(2);
        for (int i = 0; i < 8; i++) begin
            i_seg = (i % 2 == 0) ? 7'h00 : 7'h7F;
            repeat (5) @(posedge clk);
            #1;
        end
        dwell(slot_enb(2), 7'h5B, 1'b0, 40, "t2");
        dwell(slot_enb(2), 7'h7E, 1'b0, 40, "t2_late");
        dwell(slot_enb(3), 7'h73, 1'b0, 40, "t2");
        dwell(slot_enb(4), 7'h70, 1'b0, 40, "t2");
        dwell(slot_enb(5), 7'h12, 1'b1, 40, "t2");
        check("t2_slot2", 32'(o_digits[11:8]), 32'h5);
        check("t2_bad_seg", 32'(o_digits[23:20]), 32'hF);

        // 3: out-of-order sequence, then a clean frame
        dwell(slot_enb(0), 7'h30, 1'b0, 40, "t3");
        dwell(slot_enb(1), 7'h30, 1'b0, 40, "t3");
        dwell(slot_enb(3), 7'h30, 1'b0, 40, "t3");
        dwell(slot_enb(4), 7'h30, 1'b0, 40, "t3");
        dwell(slot_enb(5), 7'h30, 1'b0, 40, "t3");
        frame(7'h5F, 7'h70, 7'h7F, 7'h73, 7'h77, 7'h7E, 6'b101010, "t3");

        // 4: illegal enable mid-frame, then error clear
        dwell(slot_enb(0), 7'h30, 1'b0, 40, "t4");
        dwell(slot_enb(1), 7'h30, 1'b0, 40, "t4");
        dwell(slot_enb(2), 7'h30, 1'b0, 40, "t4");
        dwell(6'b111100, 7'h30, 1'b0, 100, "t4_illegal");
        dwell(slot_enb(3), 7'h30, 1'b0, 40, "t4");
        dwell(slot_enb(4), 7'h30, 1'b0, 40, "t4");
        dwell(slot_enb(5), 7'h30, 1'b0, 40, "t4");
        i_err_clr = 1'b1;
        @(posedge clk); #1;
        i_err_clr = 1'b0;
        m_err = 1'b0;
        check_all("t4_clr");

        // 5: blank bus long enough to time out after a frame
        frame(7'h6D, 7'h6D, 7'h79, 7'h79, 7'h33, 7'h33, 6'b110000, "t5");
        dwell(6'h3F, 7'h00, 1'b0, TMO + 10, "t5_timeout");

        // 6: reset after slot 3, then a clean frame
        for (int k = 0; k < 4; k++) dwell(slot_enb(k), seg_tab[k + 4], 1'b1, 40, "t6");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        model_reset();
        check_all("t6_in_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dwell(slot_enb(3), seg_tab[7], 1'b1, 40, "t6_after");
        dwell(slot_enb(4), seg_tab[8], 1'b1, 40, "t6_after");
        dwell(slot_enb(5), seg_tab[9], 1'b1, 40, "t6_after");
        frame(7'h77, 7'h73, 7'h7F, 7'h70, 7'h5F, 7'h5B, 6'b011001, "t6_resume");

        // Randomized frames with occasional bad codes, blanks and misordered slots
        for (int f = 0; f < 15; f++) begin
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(0, 9) == 0) dwell(6'h3F, 7'h00, 1'b0, $urandom_range(20, 60), "rnd_blank");
                rslot = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : k;
                rseg  = ($urandom_range(0, 5) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 10)];
                dwell(slot_enb(rslot), rseg, 1'($urandom), $urandom_range(30, 60), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
